// File: rtl/sync_filter_multi.sv
// Multi-channel input conditioner: per-channel flop-chain synchroniser, N-cycle
// glitch filter and registered one-cycle rise/fall pulses on the filtered level.
module sync_filter_multi #(
  parameter int unsigned       NUM_CH        = 4,
  parameter int unsigned       STAGES        = 2,
  parameter int unsigned       FILTER_CYCLES = 3,
  parameter logic [NUM_CH-1:0] RST_VAL       = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  localparam int unsigned    CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [NUM_CH-1:0][STAGES-1:0] chain_q;
  logic [NUM_CH-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0]             filt_q, filt_d;
  logic [NUM_CH-1:0]             rise_q, rise_d;
  logic [NUM_CH-1:0]             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        chain_q[i] <= {STAGES{RST_VAL[i]}};
      end
      cnt_q  <= '0;
      filt_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        chain_q[i] <= {chain_q[i][STAGES-2:0], async_in[i]};
      end
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    sync_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sync_out[i] = chain_q[i][STAGES-1];
    end
  end

  // Counter tracks consecutive disagreement; the flip and its pulse share one edge.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sync_out[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        filt_d[i] = sync_out[i];
        rise_d[i] = sync_out[i];
        fall_d[i] = ~sync_out[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign filt_out   = filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_filter_multi.sv
// Bench for sync_filter_multi: two builds (2-stage/3-cycle filter and
// 3-stage/no filter) driven together, checked against a history-window model.
module tb_sync_filter_multi;

  localparam logic [3:0] RV = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] async_in = '0;
  logic [3:0] so_a, fo_a, rp_a, fp_a;
  logic [3:0] so_b, fo_b, rp_b, fp_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_filter_multi #(
    .NUM_CH(4), .STAGES(2), .FILTER_CYCLES(3), .RST_VAL(4'b1111)
  ) u_a (
    .clk(clk), .rst(rst), .async_in(async_in),
    .sync_out(so_a), .filt_out(fo_a), .rise_pulse(rp_a), .fall_pulse(fp_a)
  );

  sync_filter_multi #(
    .NUM_CH(4), .STAGES(3), .FILTER_CYCLES(1), .RST_VAL(4'b1111)
  ) u_b (
    .clk(clk), .rst(rst), .async_in(async_in),
    .sync_out(so_b), .filt_out(fo_b), .rise_pulse(rp_b), .fall_pulse(fp_b)
  );

  // Model: sync_out is the input sampled STAGES edges ago; filt flips once the
  // last FILTER_CYCLES observed sync values all disagree with it.
  logic [3:0] ain_h[$];
  logic [3:0] sha[$];
  logic [3:0] shb[$];
  logic [3:0] m_so_a, m_fo_a, m_rp_a, m_fp_a;
  logic [3:0] m_so_b, m_fo_b, m_rp_b, m_fp_b;
  bit         valid = 1'b0;

  function automatic logic [3:0] flip_mask(input logic [3:0] h[$], input int n,
                                           input logic [3:0] filt);
    logic [3:0] m;
    bit ok;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      ok = (h.size() >= n);
      for (int k = 0; k < n && ok; k++) begin
        if (h[h.size()-1-k][c] == filt[c]) ok = 1'b0;
      end
      m[c] = ok;
    end
    return m;
  endfunction

  function automatic logic [3:0] sync_of(input logic [3:0] h[$], input int st);
    if (h.size() >= st) return h[h.size()-st];
    return RV;
  endfunction

  always @(posedge clk) begin
    logic [3:0] m;
    if (rst) begin
      ain_h.delete(); sha.delete(); shb.delete();
      m_so_a = RV; m_fo_a = RV; m_rp_a = '0; m_fp_a = '0;
      m_so_b = RV; m_fo_b = RV; m_rp_b = '0; m_fp_b = '0;
      valid = 1'b1;
    end else if (valid) begin
      sha.push_back(m_so_a);
      m = flip_mask(sha, 3, m_fo_a);
      m_rp_a = m & ~m_fo_a; m_fp_a = m & m_fo_a; m_fo_a = m_fo_a ^ m;
      shb.push_back(m_so_b);
      m = flip_mask(shb, 1, m_fo_b);
      m_rp_b = m & ~m_fo_b; m_fp_b = m & m_fo_b; m_fo_b = m_fo_b ^ m;
      ain_h.push_back(async_in);
      m_so_a = sync_of(ain_h, 2);
      m_so_b = sync_of(ain_h, 3);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("a_sync", so_a, m_so_a); chk("a_filt", fo_a, m_fo_a);
      chk("a_rise", rp_a, m_rp_a); chk("a_fall", fp_a, m_fp_a);
      chk("b_sync", so_b, m_so_b); chk("b_filt", fo_b, m_fo_b);
      chk("b_rise", rp_b, m_rp_b); chk("b_fall", fp_b, m_fp_b);
      chk("a_rise_fall_excl", rp_a & fp_a, 4'b0000);
      chk("b_rise_fall_excl", rp_b & fp_b, 4'b0000);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset and power-up indication
    rst = 1'b1; async_in = 4'b0000;
    tick(3);
    chk("t1_rst_sync", so_a, 4'b1111);
    chk("t1_rst_filt", fo_a, 4'b1111);
    chk("t1_rst_pulse", rp_a | fp_a, 4'b0000);
    rst = 1'b0;
    tick(2);
    chk("t1_sync_lat", so_a, 4'b0000);
    tick(2);
    chk("t1_filt_hold", fo_a, 4'b1111);
    chk("t1_no_early_fall", fp_a, 4'b0000);
    chk("t1_b_fall", fp_b, 4'b1111);
    tick(1);
    chk("t1_filt_low", fo_a, 4'b0000);
    chk("t1_fall", fp_a, 4'b1111);
    tick(1);
    chk("t1_fall_one_cycle", fp_a, 4'b0000);

    // Two-cycle glitch on channel 1
    tick(4);
    async_in[1] = 1'b1;
    tick(2);
    chk("t2_sync_glitch", so_a, 4'b0010);
    async_in[1] = 1'b0;
    tick(2);
    chk("t2_sync_back", so_a, 4'b0000);
    chk("t2_b_rise", rp_b, 4'b0010);
    tick(4);
    chk("t2_filt_kept", fo_a, 4'b0000);

    // Clean step on channel 2
    async_in[2] = 1'b1;
    tick(4);
    chk("t3_no_early_rise", rp_a, 4'b0000);
    tick(1);
    chk("t3_rise", rp_a, 4'b0100);
    chk("t3_filt", fo_a, 4'b0100);
    tick(1);
    chk("t3_rise_one_cycle", rp_a, 4'b0000);
    tick(3);
    async_in[2] = 1'b0;
    tick(5);
    chk("t3_fall", fp_a, 4'b0100);
    chk("t3_filt_low", fo_a, 4'b0000);

    // Channel 0 steps while channel 3 toggles every cycle
    async_in = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (i == 4) chk("t4_rise_ch0", rp_a, 4'b0001);
      async_in[3] = ~async_in[3];
    end
    chk("t4_filt", fo_a, 4'b0001);
    async_in[3] = 1'b0;
    tick(6);

    // Reset while channel 1 is mid-count
    async_in[1] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_sync", so_a, 4'b1111);
    chk("t5_rst_filt", fo_a, 4'b1111);
    chk("t5_rst_pulse", rp_a | fp_a | rp_b | fp_b, 4'b0000);
    rst = 1'b0;
    async_in = 4'b0001;
    tick(1);
    chk("t5_post_rst_pulse", rp_a | fp_a, 4'b0000);
    tick(3);
    chk("t5_no_early_fall", fp_a, 4'b0000);
    tick(1);
    chk("t5_fall", fp_a, 4'b1110);
    chk("t5_filt", fo_a, 4'b0001);

    // Unfiltered build: latency and glitch propagation
    tick(4);
    async_in[0] = 1'b0;
    tick(2);
    chk("t6_sync_hold", so_b, 4'b0001);
    tick(1);
    chk("t6_sync_lat", so_b, 4'b0000);
    tick(1);
    chk("t6_fall", fp_b, 4'b0001);
    chk("t6_filt", fo_b, 4'b0000);
    tick(6);
    async_in[0] = 1'b1;
    tick(1);
    async_in[0] = 1'b0;
    tick(3);
    chk("t6_glitch_rise", rp_b, 4'b0001);
    tick(1);
    chk("t6_glitch_fall", fp_b, 4'b0001);
    tick(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
